acc_cpu_sequencer: RTL and testbench
====================================

// Module: acc_cpu_sequencer
// PURPOSE
//  Multicycle control unit for the 16-bit accumulator CPU. Sequences fetch/decode/execute
//  over the single-port synchronous RAM and the combinational 16-bit ALU. Owns PC, IR,
//  MBR and AC. Replaces testbench-driven sequencing; sits between RAM and ALU in the CPU top.
// PARAMETERS
//  ADDR_WIDTH  16      RAM address width; PC and mem_addr width
//  WORD_WIDTH  16      instruction/data word width (opcode = [15:12], operand = [11:0])
//  RESET_PC    'h100   PC value after reset
// PORTS
//  clk        in   1           rising-edge clock
//  rst_n      in   1           asynchronous, active-low reset
//  start      in   1           leave IDLE/HALT and begin fetching at current PC
//  mem_addr   out  ADDR_WIDTH  RAM address (MAR)
//  mem_wdata  out  WORD_WIDTH  RAM write data (driven = MBR)
//  mem_rdata  in   WORD_WIDTH  RAM read data, valid the cycle after cs&oe
//  mem_cs     out  1           RAM chip select
//  mem_we     out  1           RAM write enable
//  mem_oe     out  1           RAM output enable
//  alu_a      out  WORD_WIDTH  ALU operand A (= AC)
//  alu_b      out  WORD_WIDTH  ALU operand B (= MBR)
//  alu_sel    out  3           ALU operation select
//  alu_out    in   WORD_WIDTH  ALU result (combinational)
//  pc_out, ir_out, ac_out  out  ADDR_WIDTH/WORD_WIDTH/WORD_WIDTH  architectural state, debug
//  busy       out  1           high in every state except IDLE and HALT
//  halted     out  1           high in HALT state
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, PC=RESET_PC, IR=MBR=AC=0, mem_cs/we/oe=0,
//   mem_addr=0, alu_sel=SEL_ADD, busy=0, halted=0. All outputs registered.
//  States: IDLE, FETCH, FETCH_WAIT, DECODE, MEM_RD, MEM_WAIT, EXEC, MEM_WR, HALT.
//  IDLE/HALT --start--> FETCH. start ignored while busy.
//  FETCH: mem_addr=PC, cs=1, oe=1, we=0. FETCH_WAIT: IR<=mem_rdata, PC<=PC+1 (wraps mod 2^ADDR_WIDTH).
//  DECODE on IR[15:12]; operand address = IR[11:0] zero-extended:
//   1 LOAD, 3 SUBT, 4 ADD, F AND, 6 OR -> MEM_RD (cs,oe, addr=operand); MEM_WAIT: MBR<=rdata;
//     EXEC: alu_sel set, AC<=alu_out (LOAD: AC<=MBR). -> FETCH. Total 6 cycles.
//   2 STORE -> MBR<=AC in DECODE; MEM_WR: cs=1, we=1, oe=0 for exactly 1 cycle. Total 4 cycles.
//   7 HALT -> HALT; PC not advanced further; memory idle.
//   8 SKIPCOND: IR[11:10] 00: AC<0 (signed), 01: AC==0, 10: AC>0 (signed), 11: never;
//     true -> PC<=PC+1 in DECODE. 9 JUMP: PC<=operand. A CLEAR: AC<=0. B JUMPI: PC<=AC[ADDR_WIDTH-1:0].
//     These and all unlisted opcodes (NOP) complete in DECODE -> FETCH, 3 cycles.
//  Arithmetic: WORD_WIDTH-bit, wraps, no flags; SUBT = AC - M[operand].
//  mem_cs low in DECODE/EXEC/IDLE/HALT; we and oe never high together.
//  Reset mid-operation (incl. MEM_WR): we/cs drop asynchronously; write aborted.
// STRUCTURE
//  Package acc_cpu_pkg: opcode enum (OP_LOAD=1 ... OP_JUMPI=B), state enum,
//   ALU select constants SEL_ADD=3'b001, SEL_SUB=3'b010, SEL_NOT=3'b011, SEL_OR=3'b101, SEL_AND=3'b110.
//  Single module, no sub-module; one always_ff for state/regs, one always_comb for next-state.
// TESTING
//  1 rst_n=0 mid-run -> pc_out=0x100, ac_out=0, mem_cs=mem_we=0, busy=0, halted=0 same cycle.
//  2 M[100]=0x110B, M[10B]=0x0005, start -> ac_out=0x0005 exactly 6 clks after FETCH entry.
//  3 AC=5, SUBT 0x10C (M=0x0007) -> ac_out=0xFFFE; then SKIPCOND 0x8000 -> PC advances by 2.
//  4 AC=0x1234, STORE 0x10E -> one cycle mem_we=1, mem_addr=0x10E, mem_wdata=0x1234; M[10E]=0x1234.
//  5 JUMP 0x102 then HALT at 0x102 -> pc_out=0x103, halted=1, busy=0, mem_cs=0 until start.
//  6 PC=0xFFFF, NOP fetched -> pc_out=0x0000 (wrap); AND with M=0x00FF, AC=0x1234 -> 0x0034.

Source files
------------

// File: rtl/acc_cpu_pkg.sv
// Shared types and constants for the 16-bit accumulator CPU.
// Opcodes, sequencer states and ALU operation selects.
package acc_cpu_pkg;

    typedef enum logic [3:0] {
        OP_LOAD     = 4'h1,
        OP_STORE    = 4'h2,
        OP_SUBT     = 4'h3,
        OP_ADD      = 4'h4,
        OP_OR       = 4'h6,
        OP_HALT     = 4'h7,
        OP_SKIPCOND = 4'h8,
        OP_JUMP     = 4'h9,
        OP_CLEAR    = 4'hA,
        OP_JUMPI    = 4'hB,
        OP_AND      = 4'hF
    } opcode_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_FETCH_WAIT,
        S_DECODE,
        S_MEM_RD,
        S_MEM_WAIT,
        S_EXEC,
        S_MEM_WR,
        S_HALT
    } state_e;

    localparam logic [2:0] SEL_ADD = 3'b001;
    localparam logic [2:0] SEL_SUB = 3'b010;
    localparam logic [2:0] SEL_NOT = 3'b011;
    localparam logic [2:0] SEL_OR  = 3'b101;
    localparam logic [2:0] SEL_AND = 3'b110;

    // LOAD bypasses the ALU, so it keeps whatever select was last used.
    function automatic logic [2:0] alu_sel_of(
        input logic [3:0] op,
        input logic [2:0] cur
    );
        case (op)
            OP_SUBT: return SEL_SUB;
            OP_ADD:  return SEL_ADD;
            OP_OR:   return SEL_OR;
            OP_AND:  return SEL_AND;
            default: return cur;
        endcase
    endfunction

endpackage

// File: rtl/acc_cpu_sequencer.sv
// Multicycle fetch/decode/execute sequencer for the accumulator CPU.
// Owns PC, IR, MBR and AC; every output comes straight from a register.
module acc_cpu_sequencer
    import acc_cpu_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int WORD_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = 'h100
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_WIDTH-1:0] mem_wdata,
    input  logic [WORD_WIDTH-1:0] mem_rdata,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe,
    output logic [WORD_WIDTH-1:0] alu_a,
    output logic [WORD_WIDTH-1:0] alu_b,
    output logic [2:0]            alu_sel,
    input  logic [WORD_WIDTH-1:0] alu_out,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic [WORD_WIDTH-1:0] ir_out,
    output logic [WORD_WIDTH-1:0] ac_out,
    output logic                  busy,
    output logic                  halted
);

    state_e                r_state, w_state;
    logic [ADDR_WIDTH-1:0] r_pc, w_pc;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr;
    logic [WORD_WIDTH-1:0] r_ir, w_ir;
    logic [WORD_WIDTH-1:0] r_mbr, w_mbr;
    logic [WORD_WIDTH-1:0] r_ac, w_ac;
    logic [2:0]            r_sel, w_sel;
    logic                  r_cs, w_cs;
    logic                  r_we, w_we;
    logic                  r_oe, w_oe;
    logic                  r_busy, w_busy;
    logic                  r_halted, w_halted;

    logic [3:0]            w_op;
    logic [ADDR_WIDTH-1:0] w_opnd;
    logic                  w_neg;
    logic                  w_zero;
    logic                  w_skip;

    assign w_op   = r_ir[15:12];
    assign w_opnd = ADDR_WIDTH'(r_ir[11:0]);
    assign w_neg  = r_ac[WORD_WIDTH-1];
    assign w_zero = (r_ac == '0);

    assign w_skip = ((r_ir[11:10] == 2'b00) && w_neg)
                 || ((r_ir[11:10] == 2'b01) && w_zero)
                 || ((r_ir[11:10] == 2'b10) && !w_neg && !w_zero);

    always_comb begin
        w_state  = r_state;
        w_pc     = r_pc;
        w_ir     = r_ir;
        w_mbr    = r_mbr;
        w_ac     = r_ac;
        w_sel    = r_sel;
        w_addr   = r_addr;
        w_cs     = 1'b0;
        w_we     = 1'b0;
        w_oe     = 1'b0;
        w_busy   = 1'b0;
        w_halted = 1'b0;

        case (r_state)
            S_IDLE, S_HALT: begin
                if (start) w_state = S_FETCH;
            end
            S_FETCH: w_state = S_FETCH_WAIT;
            S_FETCH_WAIT: begin
                w_ir    = mem_rdata;
                w_pc    = r_pc + ADDR_WIDTH'(1);
                w_state = S_DECODE;
            end
            S_DECODE: begin
                w_state = S_FETCH;
                case (w_op)
                    OP_LOAD, OP_SUBT, OP_ADD,
                    OP_OR, OP_AND: w_state = S_MEM_RD;
                    OP_STORE: begin
                        w_mbr   = r_ac;
                        w_state = S_MEM_WR;
                    end
                    OP_HALT: w_state = S_HALT;
                    OP_SKIPCOND: begin
                        if (w_skip) w_pc = r_pc + ADDR_WIDTH'(1);
                    end
                    OP_JUMP:  w_pc = w_opnd;
                    OP_CLEAR: w_ac = '0;
                    OP_JUMPI: w_pc = ADDR_WIDTH'(r_ac);
                    default: ;
                endcase
            end
            S_MEM_RD: w_state = S_MEM_WAIT;
            S_MEM_WAIT: begin
                w_mbr   = mem_rdata;
                w_sel   = alu_sel_of(w_op, r_sel);
                w_state = S_EXEC;
            end
            S_EXEC: begin
                w_ac    = (w_op == OP_LOAD) ? r_mbr : alu_out;
                w_state = S_FETCH;
            end
            S_MEM_WR: w_state = S_FETCH;
            default:  w_state = S_IDLE;
        endcase

        // Bus strobes are decoded from the state being entered so they register.
        case (w_state)
            S_FETCH: begin
                w_addr = w_pc;
                w_cs   = 1'b1;
                w_oe   = 1'b1;
            end
            S_MEM_RD: begin
                w_addr = w_opnd;
                w_cs   = 1'b1;
                w_oe   = 1'b1;
            end
            S_MEM_WR: begin
                w_addr = w_opnd;
                w_cs   = 1'b1;
                w_we   = 1'b1;
            end
            default: ;
        endcase

        w_busy   = (w_state != S_IDLE) && (w_state != S_HALT);
        w_halted = (w_state == S_HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_pc     <= RESET_PC;
            r_ir     <= '0;
            r_mbr    <= '0;
            r_ac     <= '0;
            r_sel    <= SEL_ADD;
            r_addr   <= '0;
            r_cs     <= 1'b0;
            r_we     <= 1'b0;
            r_oe     <= 1'b0;
            r_busy   <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_pc     <= w_pc;
            r_ir     <= w_ir;
            r_mbr    <= w_mbr;
            r_ac     <= w_ac;
            r_sel    <= w_sel;
            r_addr   <= w_addr;
            r_cs     <= w_cs;
            r_we     <= w_we;
            r_oe     <= w_oe;
            r_busy   <= w_busy;
            r_halted <= w_halted;
        end
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_mbr;
    assign mem_cs    = r_cs;
    assign mem_we    = r_we;
    assign mem_oe    = r_oe;
    assign alu_a     = r_ac;
    assign alu_b     = r_mbr;
    assign alu_sel   = r_sel;
    assign pc_out    = r_pc;
    assign ir_out    = r_ir;
    assign ac_out    = r_ac;
    assign busy      = r_busy;
    assign halted    = r_halted;

endmodule

// File: tb/tb_acc_cpu_sequencer.sv
// Bench for acc_cpu_sequencer: RAM and ALU models, an ISA-level
// interpreter filling a bus-trace scoreboard, and a bus monitor.
module tb_acc_cpu_sequencer;
    import acc_cpu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_cs;
    logic        mem_we;
    logic        mem_oe;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [2:0]  alu_sel;
    logic [15:0] alu_out;
    logic [15:0] pc_out;
    logic [15:0] ir_out;
    logic [15:0] ac_out;
    logic        busy;
    logic        halted;

    acc_cpu_sequencer u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_cs    (mem_cs),
        .mem_we    (mem_we),
        .mem_oe    (mem_oe),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .pc_out    (pc_out),
        .ir_out    (ir_out),
        .ac_out    (ac_out),
        .busy      (busy),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind: 0 fetch, 1 operand read, 2 write, 3 halt entry
    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] pc;
        logic [15:0] ac;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] ram     [0:65535];
    logic [15:0] ref_mem [0:65535];
    logic        ld_en = 1'b0;
    logic [15:0] ld_addr = '0;
    logic [15:0] ld_data = '0;
    int          cyc = 0;
    int          nvec = 0;
    int          nerr = 0;
    logic        prev_halt = 1'b0;
    logic [15:0] m_pc;
    logic [15:0] m_ac;

    always_comb begin
        case (alu_sel)
            SEL_ADD: alu_out = alu_a + alu_b;
            SEL_SUB: alu_out = alu_a - alu_b;
            SEL_NOT: alu_out = ~alu_a;
            SEL_OR:  alu_out = alu_a | alu_b;
            SEL_AND: alu_out = alu_a & alu_b;
            default: alu_out = '0;
        endcase
    end

    always @(posedge clk) begin
        if (ld_en) begin
            ram[ld_addr] <= ld_data;
        end else begin
            if (mem_cs && mem_oe) mem_rdata <= ram[mem_addr];
            if (mem_cs && mem_we) ram[mem_addr] <= mem_wdata;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        nvec++;
        if (act !== want) begin
            nerr++;
            $display("FAIL %s: got %h want %h (cycle %0d)",
                     nm, act, want, cyc);
        end
    endtask

    task automatic fail_note(input string nm, input logic [31:0] act);
        nvec++;
        nerr++;
        $display("FAIL %s: got %h want nothing (cycle %0d)", nm, act, cyc);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("we_oe_excl", 32'(mem_we & mem_oe), 32'd0);
            if (!busy) chk("idle_cs", 32'(mem_cs), 32'd0);
            if (mem_cs) begin
                if (exp_q.size() == 0) begin
                    fail_note("bus_unexpected", 32'(mem_addr));
                end else begin
                    chk("bus_kind", mem_we ? 32'd2 : 32'd1,
                        (exp_q[0].kind == 2) ? 32'd2 : 32'd1);
                    chk("bus_addr", 32'(mem_addr), 32'(exp_q[0].addr));
                    chk("bus_cycle", 32'(cyc), 32'(exp_q[0].cyc));
                    if (exp_q[0].kind == 2)
                        chk("wdata", 32'(mem_wdata), 32'(exp_q[0].data));
                    else
                        chk("oe", 32'(mem_oe), 32'd1);
                    if (exp_q[0].kind == 0) begin
                        chk("fetch_pc", 32'(pc_out), 32'(exp_q[0].pc));
                        chk("fetch_ac", 32'(ac_out), 32'(exp_q[0].ac));
                    end
                    exp_q.delete(0);
                end
            end
            if (halted && !prev_halt) begin
                if (exp_q.size() == 0) begin
                    fail_note("halt_unexpected", 32'(pc_out));
                end else begin
                    chk("halt_kind", 32'd3, 32'(exp_q[0].kind));
                    chk("halt_pc", 32'(pc_out), 32'(exp_q[0].pc));
                    chk("halt_ac", 32'(ac_out), 32'(exp_q[0].ac));
                    chk("halt_cycle", 32'(cyc), 32'(exp_q[0].cyc));
                    chk("halt_busy", 32'(busy), 32'd0);
                    exp_q.delete(0);
                end
            end
        end
        prev_halt <= halted;
    end

    task automatic push(input int k, input logic [15:0] a, d, p, acc,
                        input int c);
        exp_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        e.pc   = p;
        e.ac   = acc;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    // Instruction-level interpreter; t is the FETCH cycle of each instruction.
    task automatic model_run(input int base);
        logic [15:0] ir;
        logic [15:0] opnd;
        logic [15:0] m;
        logic        hit;
        int          t;
        t = base;
        for (int n = 0; n < 400; n++) begin
            push(0, m_pc, 16'h0, m_pc, m_ac, t);
            ir   = ref_mem[m_pc];
            m_pc = m_pc + 16'd1;
            opnd = {4'h0, ir[11:0]};
            m    = ref_mem[opnd];
            case (ir[15:12])
                4'h1, 4'h3, 4'h4, 4'h6, 4'hF: begin
                    push(1, opnd, 16'h0, 16'h0, 16'h0, t + 3);
                    case (ir[15:12])
                        4'h1:    m_ac = m;
                        4'h3:    m_ac = m_ac - m;
                        4'h4:    m_ac = m_ac + m;
                        4'h6:    m_ac = m_ac | m;
                        default: m_ac = m_ac & m;
                    endcase
                    t += 6;
                end
                4'h2: begin
                    push(2, opnd, m_ac, 16'h0, 16'h0, t + 3);
                    ref_mem[opnd] = m_ac;
                    t += 4;
                end
                4'h7: begin
                    push(3, 16'h0, 16'h0, m_pc, m_ac, t + 3);
                    return;
                end
                default: begin
                    case (ir[15:12])
                        4'h8: begin
                            case (ir[11:10])
                                2'b00:   hit = $signed(m_ac) < 0;
                                2'b01:   hit = (m_ac == 16'h0);
                                2'b10:   hit = $signed(m_ac) > 0;
                                default: hit = 1'b0;
                            endcase
                            if (hit) m_pc = m_pc + 16'd1;
                        end
                        4'h9: m_pc = opnd;
                        4'hA: m_ac = 16'h0;
                        4'hB: m_pc = m_ac;
                        default: ;
                    endcase
                    t += 3;
                end
            endcase
        end
    endtask

    task automatic put(input logic [15:0] a, input logic [15:0] d);
        ref_mem[a] = d;
        ld_addr = a;
        ld_data = d;
        ld_en = 1'b1;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        m_pc = 16'h0100;
        m_ac = 16'h0;
        rst_n = 1'b1;
    endtask

    task automatic kick();
        int t0;
        @(negedge clk);
        t0 = cyc;
        model_run(t0 + 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_prog(input int pulse_at);
        bit done;
        kick();
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            start = (i == pulse_at) && busy;
            done = halted && (exp_q.size() == 0);
        end
        start = 1'b0;
        chk("run_done", 32'(done), 32'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic gen_prog();
        logic [15:0] pos;
        logic [11:0] da;
        logic [3:0]  nops [5];
        int          n;
        nops = '{4'h0, 4'h5, 4'hC, 4'hD, 4'hE};
        for (int a = 0; a < 16; a++) begin
            logic [15:0] d;
            case ($urandom_range(0, 7))
                0: d = 16'h0000;
                1: d = 16'h8000;
                2: d = 16'h7FFF;
                3: d = 16'hFFFF;
                default: d = 16'($urandom);
            endcase
            put(16'h0200 + 16'(a), d);
        end
        pos = 16'h0100;
        n = $urandom_range(4, 16);
        for (int k = 0; k < n; k++) begin
            da = 12'h200 + 12'($urandom_range(0, 15));
            case ($urandom_range(0, 9))
                0: put(pos, {4'h1, da});
                1: put(pos, {4'h2, da});
                2: put(pos, {4'h3, da});
                3: put(pos, {4'h4, da});
                4: put(pos, {4'h6, da});
                5: put(pos, {4'hF, da});
                6: put(pos, {4'h8, 2'($urandom), 10'($urandom)});
                7: put(pos, 16'hA000);
                8: begin
                    put(pos, {4'h9, 12'(pos + 16'd2)});
                    pos = pos + 16'd1;
                    put(pos, 16'h5000);
                end
                default: put(pos, {nops[$urandom_range(0, 4)],
                                   12'($urandom)});
            endcase
            pos = pos + 16'd1;
        end
        put(pos, 16'h7000);
        put(pos + 16'd1, 16'h7000);
    endtask

    initial begin
        bit seen;
        rst_n = 1'b1;
        start = 1'b0;
        m_pc  = 16'h0100;
        m_ac  = 16'h0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_pc", 32'(pc_out), 32'h100);
        chk("rst_ac", 32'(ac_out), 32'h0);
        chk("rst_ir", 32'(ir_out), 32'h0);
        chk("rst_cs", 32'(mem_cs), 32'h0);
        chk("rst_we", 32'(mem_we), 32'h0);
        chk("rst_oe", 32'(mem_oe), 32'h0);
        chk("rst_addr", 32'(mem_addr), 32'h0);
        chk("rst_sel", 32'(alu_sel), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        put(16'h0100, 16'h110B);
        put(16'h0101, 16'h310C);
        put(16'h0102, 16'h8000);
        put(16'h0103, 16'h7000);
        put(16'h0104, 16'h4111);
        put(16'h0105, 16'h210E);
        put(16'h0106, 16'h9108);
        put(16'h0107, 16'h7000);
        put(16'h0108, 16'hF10F);
        put(16'h0109, 16'h7000);
        put(16'h010A, 16'h9112);
        put(16'h010B, 16'h0005);
        put(16'h010C, 16'h0007);
        put(16'h010E, 16'h0000);
        put(16'h010F, 16'h00FF);
        put(16'h0110, 16'hFFFF);
        put(16'h0111, 16'h1236);
        put(16'h0112, 16'h1110);
        put(16'h0113, 16'hB000);
        put(16'hFFFF, 16'h5000);
        put(16'h0000, 16'h7000);

        run_prog(-1);
        chk("store_mem", 32'(ram[16'h010E]), 32'h1234);
        chk("halt1_pc", 32'(pc_out), 32'h010A);
        chk("halt1_ac", 32'(ac_out), 32'h0034);
        chk("halt1_cs", 32'(mem_cs), 32'h0);

        run_prog(-1);
        chk("wrap_pc", 32'(pc_out), 32'h0001);
        chk("wrap_halted", 32'(halted), 32'h1);

        do_reset();
        put(16'h0100, 16'h1201);
        put(16'h0101, 16'h2202);
        put(16'h0102, 16'h7000);
        put(16'h0201, 16'hABCD);
        put(16'h0202, 16'h5555);
        kick();
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = mem_we;
        end
        chk("we_seen", 32'(seen), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_pc", 32'(pc_out), 32'h100);
        chk("mid_rst_ac", 32'(ac_out), 32'h0);
        chk("mid_rst_cs", 32'(mem_cs), 32'h0);
        chk("mid_rst_we", 32'(mem_we), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_halted", 32'(halted), 32'h0);
        @(posedge clk);
        #1 chk("write_aborted", 32'(ram[16'h0202]), 32'h5555);
        @(negedge clk);
        exp_q.delete();
        m_pc = 16'h0100;
        m_ac = 16'h0;
        rst_n = 1'b1;

        for (int r = 0; r < 25; r++) begin
            do_reset();
            gen_prog();
            run_prog($urandom_range(0, 12));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
